alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Operand-fetch/issue stage directly upstream of the 32-bit add/sub ALU. Holds a 32x32 register file,
//  accepts ALU instructions over valid/ready, drives registered A/B/ALUOp into the ALU, and writes the ALU
//  result C back into the register file. Handles read-after-write hazards by bypass or one-cycle stall.
// PARAMETERS
//  NREG   32  number of architectural registers (index width = $clog2(NREG) = 5); reg 0 reads as zero
//  DW     32  datapath width, equal to ALU A/B/C width
// PORTS
//  clk         in   1   single clock; all state updates on posedge clk
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   instruction offered
//  in_ready    out  1   stage can accept this cycle (combinational)
//  in_op       in   5   ALUOp code (00000 add, 00001 sub)
//  in_rd       in   5   destination register
//  in_rs1      in   5   source for A
//  in_rs2      in   5   source for B
//  alu_a       out  DW  registered operand A to ALU (signed)
//  alu_b       out  DW  registered operand B to ALU (signed)
//  alu_op      out  5   registered ALUOp to ALU
//  alu_c       in   DW  ALU result, valid the cycle after A/B/ALUOp were captured by the ALU
//  ext_we      in   1   external register write (load/init)
//  ext_waddr   in   5   external write address
//  ext_wdata   in   DW  external write data
//  dbg_raddr   in   5   debug read address
//  dbg_rdata   out  DW  debug read data, combinational, reflects register file contents only
//  illegal_op  out  1   one-cycle pulse when an accepted op is not add/sub
// BEHAVIOUR
//  Reset (rst=1 at posedge): all registers, alu_a, alu_b, alu_op, illegal_op -> 0; S1/S2 valid -> 0.
//  Pipeline: accept at edge k -> S1 (alu_a/b/op loaded); ALU computes C at edge k+1 -> S2 (C visible);
//   regfile written with alu_c at edge k+2 if S2 valid and S2.rd != 0. Accept-to-writeback = 2 cycles.
//  Handshake: transfer when in_valid && in_ready; inputs ignored otherwise. No buffering of unaccepted ops.
//  When no transfer, alu_a/alu_b/alu_op hold; S1 valid -> 0 (bubble; ALU recomputes but no writeback).
//  Operand read priority: rs==0 -> 0; rs==S2.rd (S2 valid, rd!=0) -> alu_c bypass; else regfile.
//  Stall: in_ready=0 iff in_valid && S1 valid && S1.rd!=0 && (in_rs1==S1.rd || in_rs2==S1.rd).
//   Exactly one bubble; next cycle the producer is in S2 and bypass applies. Otherwise in_ready=1.
//  Illegal op (not 00000/00001): accepted and issued, illegal_op pulses next cycle, S1.rd forced to 0
//   (no writeback, no hazard), since the ALU holds its previous C for unknown codes.
//  ext write: applied at posedge; same cycle as writeback to same address -> writeback wins; different
//   addresses -> both written. ext_waddr==0 ignored. ext write is not bypassed to the issuing op.
//  Arithmetic: none in this block; values pass through unmodified, two's complement, DW bits.
//  Reset mid-operation: in-flight S1/S2 ops discarded, no writeback; first accept allowed the cycle after rst.
//  Top level ties the ALU's active-low reset to ~rst; ALU Zero output is not consumed here.
// STRUCTURE
//  Shared package alu_pkg: ALUOP_ADD=5'b00000, ALUOP_SUB=5'b00001, DW, NREG, REG_AW, op-legal function.
//  One sub-module: alu_regfile (NREG x DW, 2 async read ports + debug read, 2 sync write ports with
//   writeback priority, reg 0 hardwired zero). Hazard/bypass/pipeline-valid logic stays in this module.
// TESTING
//  ext write r1=5, r2=3; issue add r3,r1,r2 -> alu_a=5,alu_b=3 next cycle; dbg r3=8 two cycles after accept.
//  add r3,r1,r2 then sub r4,r3,r1 back-to-back -> in_ready=0 one cycle, then alu_a=8 via bypass; r4=3.
//  add r3 then unrelated op then add r5,r3,r3 -> no stall, bypass from S2 gives alu_a=alu_b=8; r5=16.
//  op=5'b00111 rd=r6 -> illegal_op pulses once, r6 unchanged, no stall on following read of r6.
//  writeback r3 and ext_we r3=99 same cycle -> r3=ALU result; ext to r0 -> dbg r0 reads 0.
//  rst asserted with op in S1 -> no writeback occurs, all regs and alu_a/b/op read 0 after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and helpers for the ALU issue stage and its register file.
package alu_pkg;

  localparam int DW     = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_SUB = 5'b00001;

  function automatic logic op_legal(input logic [4:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: two operand read ports, a debug read port, and two write
// ports where the ALU writeback beats the external write on an address collision.
module alu_regfile
  import alu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_AW-1:0]        raddr1,
  input  logic [REG_AW-1:0]        raddr2,
  input  logic [REG_AW-1:0]        dbg_raddr,
  output logic signed [DW-1:0]     rdata1,
  output logic signed [DW-1:0]     rdata2,
  output logic signed [DW-1:0]     dbg_rdata,
  input  logic                     wb_we,
  input  logic [REG_AW-1:0]        wb_waddr,
  input  logic signed [DW-1:0]     wb_wdata,
  input  logic                     ext_we,
  input  logic [REG_AW-1:0]        ext_waddr,
  input  logic signed [DW-1:0]     ext_wdata
);

  logic signed [DW-1:0] regs_q [NREG];
  logic signed [DW-1:0] regs_d [NREG];

  // Writeback is applied after the external write so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (ext_we) regs_d[ext_waddr] = ext_wdata;
    if (wb_we)  regs_d[wb_waddr]  = wb_wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rdata1    = regs_q[raddr1];
  assign rdata2    = regs_q[raddr2];
  assign dbg_rdata = regs_q[dbg_raddr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage in front of the add/sub ALU: hazard stall, S2 bypass,
// registered operand issue and result writeback into the register file.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  output logic signed [DW-1:0]  alu_a,
  output logic signed [DW-1:0]  alu_b,
  output logic [4:0]            alu_op,
  input  logic signed [DW-1:0]  alu_c,
  input  logic                  ext_we,
  input  logic [REG_AW-1:0]     ext_waddr,
  input  logic signed [DW-1:0]  ext_wdata,
  input  logic [REG_AW-1:0]     dbg_raddr,
  output logic signed [DW-1:0]  dbg_rdata,
  output logic                  illegal_op
);

  logic                 s1_vld_q, s1_vld_d;
  logic [REG_AW-1:0]    s1_rd_q, s1_rd_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [REG_AW-1:0]    s2_rd_q, s2_rd_d;
  logic signed [DW-1:0] alu_a_q, alu_a_d;
  logic signed [DW-1:0] alu_b_q, alu_b_d;
  logic [4:0]           alu_op_q, alu_op_d;
  logic                 illegal_q, illegal_d;
  logic signed [DW-1:0] rf_rdata1, rf_rdata2;
  logic                 hazard, fire, wb_we;

  function automatic logic signed [DW-1:0] read_opnd(
    input logic [REG_AW-1:0]    rs,
    input logic signed [DW-1:0] rf_val,
    input logic                 byp_vld,
    input logic [REG_AW-1:0]    byp_rd,
    input logic signed [DW-1:0] byp_val
  );
    if (rs == '0)                                return '0;
    else if (byp_vld && byp_rd != '0 && rs == byp_rd) return byp_val;
    else                                         return rf_val;
  endfunction

  assign wb_we = s2_vld_q && (s2_rd_q != '0);

  alu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr1    (in_rs1),
    .raddr2    (in_rs2),
    .dbg_raddr (dbg_raddr),
    .rdata1    (rf_rdata1),
    .rdata2    (rf_rdata2),
    .dbg_rdata (dbg_rdata),
    .wb_we     (wb_we),
    .wb_waddr  (s2_rd_q),
    .wb_wdata  (alu_c),
    .ext_we    (ext_we),
    .ext_waddr (ext_waddr),
    .ext_wdata (ext_wdata)
  );

  // A producer still in S1 has no result yet; one bubble moves it to S2 where bypass applies.
  always_comb begin
    hazard    = in_valid && s1_vld_q && (s1_rd_q != '0) &&
                ((in_rs1 == s1_rd_q) || (in_rs2 == s1_rd_q));
    in_ready  = !hazard;
    fire      = in_valid && !hazard;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    s1_rd_d   = s1_rd_q;
    s1_vld_d  = fire;
    illegal_d = fire && !op_legal(in_op);
    s2_vld_d  = s1_vld_q;
    s2_rd_d   = s1_rd_q;
    if (fire) begin
      alu_a_d  = read_opnd(in_rs1, rf_rdata1, s2_vld_q, s2_rd_q, alu_c);
      alu_b_d  = read_opnd(in_rs2, rf_rdata2, s2_vld_q, s2_rd_q, alu_c);
      alu_op_d = in_op;
      // Unknown codes leave the ALU result stale, so they must never write back.
      s1_rd_d  = op_legal(in_op) ? in_rd : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_rd_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_rd_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_rd_q   <= s1_rd_d;
      s2_vld_q  <= s2_vld_d;
      s2_rd_q   <= s2_rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural add/sub ALU closing the loop
// and a queue of expected issued operands checked one cycle after each accept.
module tb_alu_issue_stage;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic signed [31:0] alu_a, alu_b, alu_c;
  logic [4:0]        alu_op;
  logic              ext_we;
  logic [4:0]        ext_waddr;
  logic signed [31:0] ext_wdata;
  logic [4:0]        dbg_raddr;
  logic signed [31:0] dbg_rdata;
  logic              illegal_op;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_c      (alu_c),
    .ext_we     (ext_we),
    .ext_waddr  (ext_waddr),
    .ext_wdata  (ext_wdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .illegal_op (illegal_op)
  );

  // ALU model: registers A op B one edge after capture, holds C on unknown codes.
  always @(posedge clk) begin
    if (rst) alu_c <= '0;
    else if (alu_op == 5'b00000) alu_c <= alu_a + alu_b;
    else if (alu_op == 5'b00001) alu_c <= alu_a - alu_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic ext(input logic [4:0] r, input logic [31:0] d);
    ext_we = 1'b1; ext_waddr = r; ext_wdata = d;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] ea, input logic [31:0] eb, input int exp_stall);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    #1;
    while (!in_ready && n < 4) begin
      tick();
      n++;
    end
    check({tag, "_stall"}, n, exp_stall);
    sb_q.push_back('{a: ea, b: eb, op: op});
    tick();
    in_valid = 1'b0;
    e = sb_q.pop_front();
    check({tag, "_a"}, alu_a, e.a);
    check({tag, "_b"}, alu_b, e.b);
    check({tag, "_op"}, {27'd0, alu_op}, {27'd0, e.op});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0; dbg_raddr = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_illegal", {31'd0, illegal_op}, 0);
    check("rst_ready", {31'd0, in_ready}, 1);

    ext(5'd1, 32'd5);
    ext(5'd2, 32'd3);
    dbg("init_r1", 5'd1, 5);
    dbg("init_r2", 5'd2, 3);

    // Basic add with two-cycle writeback
    issue("add1", 5'b00000, 5'd3, 5'd1, 5'd2, 5, 3, 0);
    dbg("add1_r3_early", 5'd3, 0);
    tick();
    dbg("add1_r3_k1", 5'd3, 0);
    tick();
    dbg("add1_r3_wb", 5'd3, 8);

    // Back-to-back dependency: one stall then bypass
    ext(5'd3, 32'd77);
    issue("raw_add", 5'b00000, 5'd3, 5'd1, 5'd2, 5, 3, 0);
    issue("raw_sub", 5'b00001, 5'd4, 5'd3, 5'd1, 8, 5, 1);
    tick(); tick();
    dbg("raw_r4", 5'd4, 3);
    dbg("raw_r3", 5'd3, 8);

    // Dependency two apart: bypass from S2 with no stall
    ext(5'd3, 32'd77);
    issue("byp_add3", 5'b00000, 5'd3, 5'd1, 5'd2, 5, 3, 0);
    issue("byp_add7", 5'b00000, 5'd7, 5'd1, 5'd1, 5, 5, 0);
    issue("byp_add5", 5'b00000, 5'd5, 5'd3, 5'd3, 8, 8, 0);
    tick(); tick();
    dbg("byp_r5", 5'd5, 16);
    dbg("byp_r7", 5'd7, 10);

    // Illegal op: pulse, no writeback, no hazard
    issue("ill", 5'b00111, 5'd6, 5'd1, 5'd2, 5, 3, 0);
    check("ill_pulse", {31'd0, illegal_op}, 1);
    issue("ill_next", 5'b00000, 5'd8, 5'd6, 5'd6, 0, 0, 0);
    check("ill_pulse_end", {31'd0, illegal_op}, 0);
    tick(); tick();
    dbg("ill_r6", 5'd6, 0);

    // Writeback beats ext write on same address; ext to r0 ignored
    issue("col", 5'b00000, 5'd3, 5'd1, 5'd2, 5, 3, 0);
    tick();
    ext(5'd3, 32'd99);
    dbg("col_r3", 5'd3, 8);
    ext(5'd0, 32'd123);
    dbg("r0_zero", 5'd0, 0);

    // Writeback and ext write to different addresses both land
    issue("dual", 5'b00001, 5'd10, 5'd1, 5'd2, 5, 3, 0);
    tick();
    ext(5'd9, 32'd42);
    dbg("dual_r10", 5'd10, 2);
    dbg("dual_r9", 5'd9, 42);

    // Reset with op in S1 discards it
    issue("rstop", 5'b00000, 5'd11, 5'd1, 5'd2, 5, 3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstop_a", alu_a, 0);
    check("rstop_b", alu_b, 0);
    check("rstop_op", {27'd0, alu_op}, 0);
    dbg("rstop_r1", 5'd1, 0);
    tick(); tick();
    dbg("rstop_r11", 5'd11, 0);
    issue("post_rst", 5'b00001, 5'd12, 5'd1, 5'd1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
